// File: rtl/sort_floats_seq_if.sv
// Valid/ready bundle for sort_floats_seq: unsorted job in (up_*), sorted result out (down_*).
// FLEN defaults to 64 when the shared configuration does not define it.
`ifndef FLEN
`define FLEN 64
`endif

interface sort_floats_seq_if #(
   parameter int N    = 3,
   parameter int FLEN = `FLEN
);
   logic                    up_valid;
   logic                    up_ready;
   logic [0:N-1][FLEN-1:0]  up_data;
   logic                    down_valid;
   logic                    down_ready;
   logic [0:N-1][FLEN-1:0]  down_data;
   logic                    down_err;

   modport master (
      output up_valid, up_data, down_ready,
      input  up_ready, down_valid, down_data, down_err
   );

   modport slave (
      input  up_valid, up_data, down_ready,
      output up_ready, down_valid, down_data, down_err
   );
endinterface

// File: rtl/sort_floats_seq.sv
// Area-lean bubble sorter: one shared f_less_or_equal comparator, one comparison per cycle.
// Optional: define SORT_FLOATS_SEQ_ABORT_ON_ERR_EN to finish a job at the first comparator error.
`ifndef FLEN
`define FLEN 64
`endif

module f_less_or_equal #(
   parameter int FLEN = `FLEN
) (
   input  logic [FLEN-1:0] a,
   input  logic [FLEN-1:0] b,
   output logic            res,
   output logic            err
);
   localparam int EW = (FLEN == 16) ? 5 : (FLEN == 32) ? 8 : 11;
   localparam int MW = FLEN - 1 - EW;

   logic a_nan, b_nan, both_zero;

   assign a_nan     = (&a[FLEN-2 -: EW]) && (|a[MW-1:0]);
   assign b_nan     = (&b[FLEN-2 -: EW]) && (|b[MW-1:0]);
   assign both_zero = ~|{a[FLEN-2:0], b[FLEN-2:0]};

   // Sign-magnitude ordering; +0 and -0 compare equal, any NaN is unordered.
   always_comb begin
      err = a_nan || b_nan;
      if (err)                        res = 1'b0;
      else if (both_zero)             res = 1'b1;
      else if (a[FLEN-1] != b[FLEN-1]) res = a[FLEN-1];
      else if (a[FLEN-1])             res = (a[FLEN-2:0] >= b[FLEN-2:0]);
      else                            res = (a[FLEN-2:0] <= b[FLEN-2:0]);
   end
endmodule

module sort_floats_seq #(
   parameter int N = 3
) (
   input  logic             clk,
   input  logic             rst,
   sort_floats_seq_if.slave bus
);
   localparam int              FLEN      = `FLEN;
   localparam int              CW        = ($clog2(N) < 1) ? 1 : $clog2(N);
   localparam logic [CW-1:0]   LAST_PASS = CW'(N - 2);

   typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

   state_t                  state;
   logic [0:N-1][FLEN-1:0]  buf_q, buf_nxt, down_data_q;
   logic [CW-1:0]           pass_q, idx_q, idx_nxt;
   logic                    err_q, up_ready_q, down_valid_q, down_err_q;
   logic                    cmp_res, cmp_err, end_of_pass, last_cmp, stop;

   assign idx_nxt = idx_q + 1'b1;

   f_less_or_equal #(.FLEN(FLEN)) u_cmp (
      .a   (buf_q[idx_q]),
      .b   (buf_q[idx_nxt]),
      .res (cmp_res),
      .err (cmp_err)
   );

   assign end_of_pass = (idx_q == LAST_PASS - pass_q);
   assign last_cmp    = (pass_q == LAST_PASS) && end_of_pass;
`ifdef SORT_FLOATS_SEQ_ABORT_ON_ERR_EN
   assign stop = last_cmp || cmp_err;
`else
   assign stop = last_cmp;
`endif

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      buf_nxt = buf_q;
      if (!cmp_res) begin
         buf_nxt[idx_q]   = buf_q[idx_nxt];
         buf_nxt[idx_nxt] = buf_q[idx_q];
      end
   end

   // NOTE: the element buffer is pure datapath and is overwritten on every accept, so it has no reset.
   always_ff @(posedge clk) begin
      if (state == IDLE && bus.up_valid && up_ready_q) buf_q <= bus.up_data;
      else if (state == CMP)                            buf_q <= buf_nxt;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state        <= IDLE;
         up_ready_q   <= 1'b1;
         down_valid_q <= 1'b0;
         down_err_q   <= 1'b0;
         down_data_q  <= '0;
         pass_q       <= '0;
         idx_q        <= '0;
         err_q        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.up_valid && up_ready_q) begin
                  err_q      <= 1'b0;
                  pass_q     <= '0;
                  idx_q      <= '0;
                  up_ready_q <= 1'b0;
                  state      <= CMP;
               end
            end
            CMP: begin
               err_q <= err_q | cmp_err;
               if (stop) begin
                  pass_q <= '0;
                  idx_q  <= '0;
                  state  <= DONE;
               end else if (end_of_pass) begin
                  idx_q  <= '0;
                  pass_q <= pass_q + 1'b1;
               end else begin
                  idx_q  <= idx_nxt;
               end
            end
            DONE: begin
               // First DONE cycle registers the result; afterwards wait for the consumer.
               if (!down_valid_q) begin
                  down_valid_q <= 1'b1;
                  down_data_q  <= buf_q;
                  down_err_q   <= err_q;
               end else if (bus.down_ready) begin
                  down_valid_q <= 1'b0;
                  up_ready_q   <= 1'b1;
                  state        <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.up_ready   = up_ready_q;
   assign bus.down_valid = down_valid_q;
   assign bus.down_data  = down_data_q;
   assign bus.down_err   = down_err_q;
endmodule

// File: tb/tb_sort_floats_seq.sv
// Scoreboard bench for sort_floats_seq: directed and random jobs on an N=3 instance,
// plus random-only N=4 and N=2 instances, all checked against a stable reference sort.
module tb_sort_floats_seq;
   typedef logic [63:0] f64_t;
   typedef f64_t        f64_q_t[$];

   localparam f64_t M1   = 64'hBFF0000000000000;
   localparam f64_t P1   = 64'h3FF0000000000000;
   localparam f64_t P2   = 64'h4000000000000000;
   localparam f64_t P3   = 64'h4008000000000000;
   localparam f64_t QNAN = 64'h7FF8000000000000;
`ifdef SORT_FLOATS_SEQ_ABORT_ON_ERR_EN
   localparam int NAN_LAT = 2;
`else
   localparam int NAN_LAT = 4;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic rst_l = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   function automatic bit is_nan(input f64_t v);
      return (&v[62:52]) && (|v[51:0]);
   endfunction

   // Stable insertion sort on real values: equal values keep arrival order.
   function automatic f64_q_t ref_sort(input f64_q_t v);
      f64_q_t r;
      foreach (v[i]) begin
         int pos;
         pos = r.size();
         while (pos > 0 && $bitstoreal(r[pos-1]) > $bitstoreal(v[i])) pos--;
         r.insert(pos, v[i]);
      end
      return r;
   endfunction

   function automatic f64_t rand_f64();
      f64_t pool [8];
      f64_t v;
      pool = '{64'h0, 64'h8000000000000000, M1, P1, P2, P3,
               64'h7FF0000000000000, 64'hFFF0000000000000};
      if ($urandom_range(0, 1) == 1) return pool[$urandom_range(0, 7)];
      v = {$urandom, $urandom};
      if (v[62:52] == 11'h7FF) v[62] = 1'b0;
      return v;
   endfunction

   initial begin
      rst_l = 1'b0;
      repeat (2) @(negedge clk);
      rst_l = 1'b1;
   end

   // ---------------- N=3 instance: directed + random ----------------
   sort_floats_seq_if #(.N(3)) bus3 ();
   sort_floats_seq #(.N(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

   typedef struct {
      logic [0:2][63:0] data;
      bit               chk;
      bit               err;
      int               lat;
      int               hold;
      int               acc;
   } exp3_t;

   exp3_t sb3[$];
   bit    seen3 = 0;
   bit    drop3 = 0;
   int    wait3 = 0;
   int    hs3   = 0;

   task automatic send3(input logic [0:2][63:0] d, input bit chk, input int lat,
                        input int hold, input bit gap);
      exp3_t  e;
      f64_q_t q;
      int     k;
      bus3.up_data  = d;
      bus3.up_valid = 1'b1;
      k = 0;
      while (!bus3.up_ready && k < 200) begin
         @(negedge clk);
         k++;
      end
      if (!bus3.up_ready) begin
         check("accept_timeout", bus3.up_ready, 1);
         bus3.up_valid = 1'b0;
         return;
      end
      e.acc = cyc + 1;
      e.err = 1'b0;
      for (int i = 0; i < 3; i++) begin
         q.push_back(d[i]);
         if (is_nan(d[i])) e.err = 1'b1;
      end
      q = ref_sort(q);
      for (int i = 0; i < 3; i++) e.data[i] = q[i];
      e.chk  = chk;
      e.lat  = lat;
      e.hold = hold;
      @(posedge clk);
      sb3.push_back(e);
      if (gap) check("accept_gap", e.acc - hs3, 1);
      #1 bus3.up_valid = 1'b0;
      @(negedge clk);
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         seen3 = 0;
         drop3 = 0;
         wait3 = 0;
         bus3.down_ready = 1'b0;
      end else begin
         if (drop3) begin
            check("drop_valid", bus3.down_valid, 0);
            check("bubble_up_ready", bus3.up_ready, 1);
            drop3 = 0;
         end
         if (bus3.down_valid) begin
            if (sb3.size() == 0) begin
               check("unexpected_valid", bus3.down_valid, 0);
               bus3.down_ready = 1'b1;
            end else begin
               if (!seen3) begin
                  check("latency", cyc - sb3[0].acc, sb3[0].lat);
                  seen3 = 1;
               end
               if (sb3[0].chk) check("data", bus3.down_data, sb3[0].data);
               check("err", bus3.down_err, sb3[0].err);
               check("up_ready_done", bus3.up_ready, 0);
               wait3++;
               bus3.down_ready = (wait3 > sb3[0].hold);
               if (bus3.down_ready) begin
                  hs3 = cyc + 1;
                  void'(sb3.pop_front());
                  seen3 = 0;
                  wait3 = 0;
                  drop3 = 1;
               end
            end
         end else begin
            bus3.down_ready = 1'b0;
            if (sb3.size() > 0) check("up_ready_busy", bus3.up_ready, 0);
         end
      end
   end

   // ---------------- N=4 and N=2 instances: random only ----------------
   for (genvar g = 0; g < 2; g++) begin : lane
      localparam int LN  = (g == 0) ? 4 : 2;
      localparam int LAT = LN * (LN - 1) / 2 + 1;

      typedef struct {
         logic [0:LN-1][63:0] data;
         int                  acc;
      } le_t;

      sort_floats_seq_if #(.N(LN)) bus ();
      sort_floats_seq #(.N(LN)) dut (.clk(clk), .rst(rst_l), .bus(bus));

      le_t                 sb[$];
      le_t                 e;
      f64_q_t              q;
      logic [0:LN-1][63:0] d;
      bit                  done = 0;
      bit                  seen = 0;
      int                  k;

      initial begin
         bus.up_valid = 1'b0;
         bus.up_data  = '0;
         @(posedge rst_l);
         @(negedge clk);
         for (int j = 0; j < 30; j++) begin
            q = {};
            for (int i = 0; i < LN; i++) begin
               d[i] = rand_f64();
               q.push_back(d[i]);
            end
            q = ref_sort(q);
            for (int i = 0; i < LN; i++) e.data[i] = q[i];
            bus.up_data  = d;
            bus.up_valid = 1'b1;
            k = 0;
            while (!bus.up_ready && k < 200) begin
               @(negedge clk);
               k++;
            end
            if (!bus.up_ready) begin
               check($sformatf("n%0d_accept_timeout", LN), bus.up_ready, 1);
               break;
            end
            e.acc = cyc + 1;
            @(posedge clk);
            sb.push_back(e);
            #1 bus.up_valid = 1'b0;
            @(negedge clk);
         end
         bus.up_valid = 1'b0;
         k = 0;
         while (sb.size() > 0 && k < 500) begin
            @(negedge clk);
            k++;
         end
         if (sb.size() > 0) check($sformatf("n%0d_drain_timeout", LN), sb.size(), 0);
         done = 1;
      end

      always @(negedge clk) begin
         if (!rst_l) begin
            bus.down_ready = 1'b0;
            seen = 0;
         end else if (bus.down_valid) begin
            if (sb.size() == 0) begin
               check($sformatf("n%0d_unexpected_valid", LN), bus.down_valid, 0);
               bus.down_ready = 1'b1;
            end else begin
               if (!seen) begin
                  check($sformatf("n%0d_latency", LN), cyc - sb[0].acc, LAT);
                  check($sformatf("n%0d_data", LN), bus.down_data, sb[0].data);
                  check($sformatf("n%0d_err", LN), bus.down_err, 0);
                  seen = 1;
               end
               bus.down_ready = ($urandom_range(0, 1) == 1);
               if (bus.down_ready) begin
                  void'(sb.pop_front());
                  seen = 0;
               end
            end
         end else begin
            bus.down_ready = 1'b0;
         end
      end
   end

   // ---------------- main sequence ----------------
   initial begin
      logic [0:2][63:0] d;
      int               k;
      bus3.up_valid  = 1'b0;
      bus3.up_data   = '0;
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_up_ready", bus3.up_ready, 1);
      check("rst_down_valid", bus3.down_valid, 0);
      check("rst_down_err", bus3.down_err, 0);
      check("rst_down_data", bus3.down_data, 0);
      rst = 1'b1;
      @(negedge clk);

      send3({P3, P1, P2}, 1, 4, 0, 0);
      send3({P2, M1, P2}, 1, 4, 5, 0);
      send3({P1, P3, P2}, 1, 4, 0, 1);
      send3({P1, QNAN, P2}, 0, NAN_LAT, 0, 1);

      k = 0;
      while (sb3.size() > 0 && k < 200) begin
         @(negedge clk);
         k++;
      end
      @(negedge clk);
      // Accept a job, then reset one cycle later: the job must vanish.
      bus3.up_data  = {P3, P2, P1};
      bus3.up_valid = 1'b1;
      check("pre_abort_up_ready", bus3.up_ready, 1);
      @(posedge clk);
      #1 bus3.up_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      check("mid_rst_up_ready", bus3.up_ready, 1);
      check("mid_rst_down_valid", bus3.down_valid, 0);
      repeat (8) @(negedge clk);
      check("mid_rst_no_valid", bus3.down_valid, 0);
      send3({P2, P1, P3}, 1, 4, 0, 0);

      for (int j = 0; j < 40; j++) begin
         for (int i = 0; i < 3; i++) d[i] = rand_f64();
         send3(d, 1, 4, $urandom_range(0, 3), 0);
      end

      k = 0;
      while (sb3.size() > 0 && k < 500) begin
         @(negedge clk);
         k++;
      end
      if (sb3.size() > 0) check("drain_timeout", sb3.size(), 0);

      k = 0;
      while (!(lane[0].done && lane[1].done) && k < 5000) begin
         @(negedge clk);
         k++;
      end
      if (!(lane[0].done && lane[1].done)) check("lanes_timeout", {lane[0].done, lane[1].done}, 2'b11);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
